// File: rtl/seq01110_pkg.sv
// seq01110_pkg
// Shared definitions for the 01110-flag line protocol.
//   FLAG / FLAG_LEN : flag pattern, transmitted bit 4 first (0,1,1,1,0)
//   tx_state_t      : transmitter FSM states
//   stuff_st_t      : suffix states of the bit-stuffing tracker
//   flag_bit()      : flag bit for a transmit position 0..4 (position 0 = FLAG[4])
package seq01110_pkg;

    localparam logic [4:0] FLAG     = 5'b01110;
    localparam int         FLAG_LEN = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OPEN    = 3'd1,
        PAYLOAD = 3'd2,
        STUFF   = 3'd3,
        CLOSE   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        S0    = 3'd1,
        S01   = 3'd2,
        S011  = 3'd3,
        S0111 = 3'd4
    } stuff_st_t;

    // Position 0 is the first bit on the line, which is the flag MSB.
    function automatic logic flag_bit(input logic [2:0] pos);
        logic b;
        case (pos)
            3'd0:    b = FLAG[4];
            3'd1:    b = FLAG[3];
            3'd2:    b = FLAG[2];
            3'd3:    b = FLAG[1];
            3'd4:    b = FLAG[0];
            default: b = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/seq_tx01110_stuff_tracker.sv
// stuff_tracker
// Tracks the suffix of the transmitted payload stream and flags when a
// stuffed 1 must follow the current bit.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset, tracker -> NONE
//   init      : load S0 (the opening flag has just ended in 0)
//   bit_valid : a payload bit is being sent this cycle
//   bit_in    : value of that payload bit
//   stuffed   : a stuffed 1 is being sent this cycle, tracker -> NONE
//   stuff_due : the bit being sent now completes 0111, so a stuff follows
module stuff_tracker
    import seq01110_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic bit_valid,
    input  logic bit_in,
    input  logic stuffed,
    output logic stuff_due
);

    stuff_st_t st_r;

    function automatic stuff_st_t next_st(input stuff_st_t cur, input logic b);
        stuff_st_t n;
        if (!b) begin
            n = S0;
        end else begin
            case (cur)
                S0:      n = S01;
                S01:     n = S011;
                S011:    n = S0111;
                NONE:    n = NONE;
                default: n = NONE;
            endcase
        end
        return n;
    endfunction

    // Suffix-state register; init and stuffed override ordinary payload bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_r <= NONE;
        end else if (init) begin
            st_r <= S0;
        end else if (stuffed) begin
            st_r <= NONE;
        end else if (bit_valid) begin
            st_r <= next_st(st_r, bit_in);
        end else begin
            st_r <= st_r;
        end
    end

    // Looks one bit ahead so the FSM can schedule the stuff for the very next cycle.
    always_comb begin
        stuff_due = 1'b0;
        if (bit_valid && bit_in && (st_r == S011)) begin
            stuff_due = 1'b1;
        end else begin
            stuff_due = 1'b0;
        end
    end

endmodule

// File: rtl/seq_tx01110.sv
// seq_tx01110
// Serial frame transmitter: opening flag 01110, W-bit payload MSB-first with
// bit stuffing after every 0111, closing flag 01110. One bit per clock.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (abandons any partial frame)
//   start : frame request, honoured only while ready=1
//   data  : payload, captured on the accepted start
//   a     : registered serial line, idles at 1
//   ready : idle and able to accept start
//   done  : one-cycle pulse with the last closing-flag bit on a
module seq_tx01110
    import seq01110_pkg::*;
#(
    parameter int W = 20
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] data,
    output logic         a,
    output logic         ready,
    output logic         done
);

    localparam int            CW       = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);
    localparam logic [CW-1:0] PAY_END  = CW'(W);
    localparam logic [2:0]    FLAG_END = 3'(FLAG_LEN - 1);

    tx_state_t     state_r;
    logic [2:0]    flag_idx_r;
    logic [CW-1:0] pay_idx_r;
    logic [W-1:0]  shift_r;
    logic          a_r;
    logic          ready_r;
    logic          done_r;

    logic          flag_end_s;
    logic          trk_init_s;
    logic          trk_valid_s;
    logic          trk_stuffed_s;
    logic          stuff_due_s;

    // The FSM state names the bit to be launched at the next edge, so a lags
    // the state by one cycle; that lag is the one-cycle start latency.

    // Tracker strobes derived from the bit currently being launched.
    always_comb begin
        flag_end_s    = (flag_idx_r == FLAG_END);
        trk_init_s    = 1'b0;
        trk_valid_s   = 1'b0;
        trk_stuffed_s = 1'b0;
        case (state_r)
            OPEN:    trk_init_s    = flag_end_s;
            PAYLOAD: trk_valid_s   = 1'b1;
            STUFF:   trk_stuffed_s = 1'b1;
            default: trk_init_s    = 1'b0;
        endcase
    end

    stuff_tracker u_tracker (
        .clk       (clk),
        .rst       (rst),
        .init      (trk_init_s),
        .bit_valid (trk_valid_s),
        .bit_in    (shift_r[W-1]),
        .stuffed   (trk_stuffed_s),
        .stuff_due (stuff_due_s)
    );

    // Main FSM with registered line, ready and done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            flag_idx_r <= 3'd0;
            pay_idx_r  <= {CW{1'b0}};
            shift_r    <= {W{1'b0}};
            a_r        <= 1'b1;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    a_r        <= 1'b1;
                    done_r     <= 1'b0;
                    flag_idx_r <= 3'd0;
                    pay_idx_r  <= {CW{1'b0}};
                    // ready_r is still 0 on the done cycle, which blocks an accept there.
                    if (ready_r && start) begin
                        shift_r <= data;
                        ready_r <= 1'b0;
                        state_r <= OPEN;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end

                OPEN: begin
                    a_r     <= flag_bit(flag_idx_r);
                    done_r  <= 1'b0;
                    ready_r <= 1'b0;
                    if (flag_end_s) begin
                        flag_idx_r <= 3'd0;
                        state_r    <= PAYLOAD;
                    end else begin
                        flag_idx_r <= flag_idx_r + 3'd1;
                        state_r    <= OPEN;
                    end
                end

                PAYLOAD: begin
                    a_r       <= shift_r[W-1];
                    shift_r   <= {shift_r[W-2:0], 1'b0};
                    pay_idx_r <= pay_idx_r + CW'(1);
                    done_r    <= 1'b0;
                    ready_r   <= 1'b0;
                    if (stuff_due_s) begin
                        state_r <= STUFF;
                    end else if (pay_idx_r == LAST_IDX) begin
                        state_r <= CLOSE;
                    end else begin
                        state_r <= PAYLOAD;
                    end
                end

                STUFF: begin
                    a_r     <= 1'b1;
                    done_r  <= 1'b0;
                    ready_r <= 1'b0;
                    if (pay_idx_r == PAY_END) begin
                        state_r <= CLOSE;
                    end else begin
                        state_r <= PAYLOAD;
                    end
                end

                CLOSE: begin
                    a_r     <= flag_bit(flag_idx_r);
                    ready_r <= 1'b0;
                    if (flag_end_s) begin
                        done_r     <= 1'b1;
                        flag_idx_r <= 3'd0;
                        state_r    <= IDLE;
                    end else begin
                        done_r     <= 1'b0;
                        flag_idx_r <= flag_idx_r + 3'd1;
                        state_r    <= CLOSE;
                    end
                end

                default: begin
                    state_r    <= IDLE;
                    flag_idx_r <= 3'd0;
                    pay_idx_r  <= {CW{1'b0}};
                    a_r        <= 1'b1;
                    ready_r    <= 1'b1;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign a     = a_r;
    assign ready = ready_r;
    assign done  = done_r;

endmodule

// File: tb/tb_seq_tx01110.sv
// tb_seq_tx01110
// Directed bench for seq_tx01110 (W=20): captures each frame bit by bit and
// compares it with an independently written stuffing encoder, hand-computed
// frame lengths, flag occurrence count/positions, handshake and reset behaviour.
module tb_seq_tx01110;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] data;
    logic        a;
    logic        ready;
    logic        done;

    int total = 0;
    int bad   = 0;

    seq_tx01110 #(.W(20)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .a     (a),
        .ready (ready),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference encoder: stuff a 1 whenever the last four line bits read 0111.
    function automatic void model(input logic [19:0] d, output logic [63:0] v, output int n);
        logic [4:0] f;
        logic [3:0] h;
        f = 5'b01110;
        v = 64'd0;
        n = 0;
        for (int i = 4; i >= 0; i--) begin
            v = {v[62:0], f[i]};
            n++;
        end
        h = 4'b1110;
        for (int i = 19; i >= 0; i--) begin
            v = {v[62:0], d[i]};
            n++;
            h = {h[2:0], d[i]};
            if (h == 4'b0111) begin
                v = {v[62:0], 1'b1};
                n++;
                h = {h[2:0], 1'b1};
            end
        end
        for (int i = 4; i >= 0; i--) begin
            v = {v[62:0], f[i]};
            n++;
        end
    endfunction

    // mode 0: single start pulse; 1: start held through the frame; 2: start raised on the done cycle.
    // exp_len < 0 takes the length from the reference encoder.
    task automatic run_frame(input logic [19:0] d, input int exp_len, input int mode);
        logic [63:0] got;
        logic [63:0] expv;
        logic [4:0]  win;
        int          mlen;
        int          len;
        int          n;
        int          cnt;
        int          p1;
        int          p2;
        bit          seen;
        model(d, expv, mlen);
        if (exp_len < 0) exp_len = mlen;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_before", 64'(ready), 64'd1);
        data  = d;
        start = 1'b1;
        @(negedge clk);
        if (mode != 1) start = 1'b0;
        check("accept_ready", 64'(ready), 64'd0);
        check("accept_a", 64'(a), 64'd1);
        got  = 64'd0;
        len  = 0;
        seen = 1'b0;
        win  = 5'b11111;
        cnt  = 0;
        p1   = 0;
        p2   = 0;
        while (!seen && len < 64) begin
            @(negedge clk);
            got = {got[62:0], a};
            len++;
            win = {win[3:0], a};
            if (win == 5'b01110) begin
                cnt++;
                if (cnt == 1) p1 = len;
                p2 = len;
            end
            if (done) begin
                seen = 1'b1;
                if (mode == 2) start = 1'b1;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("frame_len", 64'(len), 64'(exp_len));
        check("frame_bits", got, expv);
        check("flag_count", 64'(cnt), 64'd2);
        check("flag_pos_open", 64'(p1), 64'd5);
        check("flag_pos_close", 64'(p2), 64'(exp_len));
        @(negedge clk);
        start = 1'b0;
        check("post_a", 64'(a), 64'd1);
        check("post_ready", 64'(ready), 64'd1);
        check("post_done", 64'(done), 64'd0);
        @(negedge clk);
        check("idle_a", 64'(a), 64'd1);
        check("idle_ready", 64'(ready), 64'd1);
    endtask

    logic [19:0] words [7];

    initial begin
        words[0] = 20'h3A5C1;
        words[1] = 20'h0F0F0;
        words[2] = 20'hB6DB6;
        words[3] = 20'h12345;
        words[4] = 20'hCAFE5;
        words[5] = 20'h7BDE7;
        words[6] = 20'h55555;

        rst   = 1'b1;
        start = 1'b0;
        data  = 20'h00000;
        repeat (3) @(negedge clk);
        check("reset_a", 64'(a), 64'd1);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed words with hand-counted frame lengths.
        run_frame(20'h00000, 30, 0);
        run_frame(20'hE0000, 31, 0);
        run_frame(20'h77777, 35, 0);
        run_frame(20'hFFFFF, 31, 0);

        // Further fixed words, lengths from the reference encoder.
        for (int i = 0; i < 7; i++) begin
            run_frame(words[i], -1, 0);
        end

        // Handshake: held start and start on the done cycle each give one frame.
        run_frame(20'hA5A5A, -1, 1);
        run_frame(20'h77777, 35, 2);

        // Reset during payload bit 7 abandons the frame.
        data  = 20'hFFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_a", 64'(a), 64'd1);
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_idle_a", 64'(a), 64'd1);
        run_frame(20'h00000, 30, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
